// File: rtl/kyber_buf_pkg.sv
// Shared types and helpers for the polynomial buffer port arbiter.
//   buf_state_e : arbiter FSM state
//   DEF_AW/DW   : default buffer address / coefficient widths
//   tag_width   : bits needed to name one of n channels
//   cnt_width   : bits for the in-flight read counter given the read latency
package kyber_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } buf_state_e;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 12;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // In-flight reads peak at RD_LAT+1 (issue register plus RD_LAT memory stages).
    function automatic int unsigned cnt_width(input int unsigned rd_lat);
        return $clog2(rd_lat + 2);
    endfunction

endpackage

// File: rtl/poly_rd_tag_pipe.sv
// Read tag pipeline: follows each forwarded read through the buffer so its data can be
// routed back to the issuing channel regardless of later owner changes.
//   clk, rst_n : clock, async active-low reset (clears all tags)
//   in_valid   : a read is being forwarded on this edge
//   in_tag     : issuing channel of that read
//   out_valid  : mem_rdata for the oldest read is present this cycle
//   out_tag    : its issuing channel
module poly_rd_tag_pipe #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned TW     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag
);

    // Stage 0 lines up with mem_ren, stage RD_LAT with mem_rdata.
    localparam int unsigned DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0] valid_q;
    logic [TW-1:0]    tag_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/poly_buf_port_arb.sv
// Registered port arbiter for one dual-port polynomial buffer shared by NUM_CH channels.
//   sel_valid/sel        : owner request from the controller (sel_valid low releases)
//   ch_wen/waddr/wdata   : packed per-channel write ports, channel i at [i*W +: W]
//   ch_ren/raddr         : packed per-channel read ports
//   err_clr              : clears err_vec
//   mem_*                : registered buffer ports; mem_rdata arrives RD_LAT after mem_ren
//   ch_rdata/ch_rvalid   : returned read data and one-hot owner-at-issue of that data
//   gnt/gnt_valid        : current owner, valid in GRANT only
//   busy                 : not idle, or reads still in flight
//   err_vec              : sticky per-channel flag for dropped (non-owner) accesses
module poly_buf_port_arb
    import kyber_buf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned CW    = tag_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_valid,
    input  logic [CW-1:0]        sel,
    input  logic [NUM_CH-1:0]    ch_wen,
    input  logic [NUM_CH*AW-1:0] ch_waddr,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]    ch_ren,
    input  logic [NUM_CH*AW-1:0] ch_raddr,
    input  logic                 err_clr,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_waddr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_ren,
    output logic [AW-1:0]        mem_raddr,
    input  logic [DW-1:0]        mem_rdata,
    output logic [DW-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]    ch_rvalid,
    output logic [CW-1:0]        gnt,
    output logic                 gnt_valid,
    output logic                 busy,
    output logic [NUM_CH-1:0]    err_vec
);

    localparam int unsigned IW       = cnt_width(RD_LAT);
    localparam logic [CW:0] CH_LIMIT = (CW+1)'(NUM_CH);

    buf_state_e        state_q, state_d;
    logic [CW-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]     inflight_q, inflight_d;

    logic              sel_ok;
    logic              fwd;
    logic              fwd_wen, fwd_ren;
    logic [AW-1:0]     own_waddr, own_raddr;
    logic [DW-1:0]     own_wdata;
    logic              ret_valid;
    logic [CW-1:0]     ret_tag;

    logic              mem_wen_q, mem_ren_q;
    logic [AW-1:0]     mem_waddr_q, mem_raddr_q;
    logic [DW-1:0]     mem_wdata_q, ch_rdata_q;
    logic [NUM_CH-1:0] ch_rvalid_q, ch_rvalid_d;
    logic [NUM_CH-1:0] err_q, err_d;

    // Out-of-range indices never become owners, even with sel_valid high.
    assign sel_ok = sel_valid && ({1'b0, sel} < CH_LIMIT);

    // Only the registered owner is forwarded, and only while in GRANT.
    assign fwd       = (state_q == GRANT);
    assign fwd_wen   = fwd && ch_wen[gnt_q];
    assign fwd_ren   = fwd && ch_ren[gnt_q];
    assign own_waddr = ch_waddr[gnt_q*AW +: AW];
    assign own_wdata = ch_wdata[gnt_q*DW +: DW];
    assign own_raddr = ch_raddr[gnt_q*AW +: AW];

    poly_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .TW     (CW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fwd_ren),
        .in_tag    (gnt_q),
        .out_valid (ret_valid),
        .out_tag   (ret_tag)
    );

    // Owner FSM. A change of owner while reads are outstanding waits in DRAIN; the
    // destination is whatever sel_valid/sel says on the edge the drain completes.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = GRANT;
                    gnt_d   = sel;
                end
            end
            GRANT: begin
                if (!sel_valid || (sel_ok && (sel != gnt_q))) begin
                    if (inflight_q == '0) begin
                        if (sel_ok) begin
                            gnt_d = sel;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    if (sel_ok) begin
                        state_d = GRANT;
                        gnt_d   = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({fwd_ren, ret_valid})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // A new stray access outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((ch_wen[i] || ch_ren[i]) && !(fwd && (gnt_q == CW'(i)))) begin
                err_d[i] = 1'b1;
            end else if (err_clr) begin
                err_d[i] = 1'b0;
            end
        end
    end

    assign ch_rvalid_d = ret_valid ? (NUM_CH'(1) << ret_tag) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            inflight_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            ch_rdata_q  <= '0;
            ch_rvalid_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            inflight_q  <= inflight_d;
            mem_wen_q   <= fwd_wen;
            mem_ren_q   <= fwd_ren;
            ch_rvalid_q <= ch_rvalid_d;
            err_q       <= err_d;
            // Addresses and data hold their last value when nothing is forwarded.
            if (fwd_wen) begin
                mem_waddr_q <= own_waddr;
                mem_wdata_q <= own_wdata;
            end
            if (fwd_ren) begin
                mem_raddr_q <= own_raddr;
            end
            if (ret_valid) begin
                ch_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_wen   = mem_wen_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ren   = mem_ren_q;
    assign mem_raddr = mem_raddr_q;
    assign ch_rdata  = ch_rdata_q;
    assign ch_rvalid = ch_rvalid_q;
    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == GRANT);
    assign busy      = (state_q != IDLE) || (inflight_q != '0);
    assign err_vec   = err_q;

endmodule

// File: tb/tb_poly_buf_port_arb.sv
// Bench for poly_buf_port_arb: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model; a second 3-channel instance covers out-of-range sel.
module tb_poly_buf_port_arb;

    localparam int NCH    = 4;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_valid;
    logic [1:0]  sel;
    logic [3:0]  ch_wen, ch_ren;
    logic [31:0] ch_waddr, ch_raddr;
    logic [47:0] ch_wdata;
    logic        err_clr;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_waddr, mem_raddr;
    logic [11:0] mem_wdata, ch_rdata;
    logic [11:0] mem_rdata = '0;
    logic [3:0]  ch_rvalid, err_vec;
    logic [1:0]  gnt;
    logic        gnt_valid, busy;

    // Second instance, 3 channels, only the owner request is exercised.
    logic        sel_valid3;
    logic [1:0]  sel3;
    logic        mem_wen3, mem_ren3, gnt_valid3, busy3;
    logic [7:0]  mem_waddr3, mem_raddr3;
    logic [11:0] mem_wdata3, ch_rdata3;
    logic [2:0]  ch_rvalid3, err_vec3;
    logic [1:0]  gnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_buf_port_arb #(.NUM_CH(4), .AW(8), .DW(12), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel(sel),
        .ch_wen(ch_wen), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
        .ch_ren(ch_ren), .ch_raddr(ch_raddr), .err_clr(err_clr),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .gnt(gnt), .gnt_valid(gnt_valid),
        .busy(busy), .err_vec(err_vec)
    );

    poly_buf_port_arb #(.NUM_CH(3), .AW(8), .DW(12), .RD_LAT(RD_LAT)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid3), .sel(sel3),
        .ch_wen(3'b000), .ch_waddr(24'h0), .ch_wdata(36'h0),
        .ch_ren(3'b000), .ch_raddr(24'h0), .err_clr(1'b0),
        .mem_wen(mem_wen3), .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3),
        .mem_ren(mem_ren3), .mem_raddr(mem_raddr3), .mem_rdata(12'h0),
        .ch_rdata(ch_rdata3), .ch_rvalid(ch_rvalid3), .gnt(gnt3), .gnt_valid(gnt_valid3),
        .busy(busy3), .err_vec(err_vec3)
    );

    // Buffer contents are a fixed function of the address; 0x10 holds 0x123.
    function automatic logic [11:0] rom(input logic [7:0] a);
        return 12'h123 + {4'h0, a} - 12'h010;
    endfunction

    // Buffer with RD_LAT = 1.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= rom(mem_raddr);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        int         tag;
        logic [7:0] addr;
    } rd_t;

    rd_t         pend[$];
    int          m_st;   // 0 idle, 1 grant, 2 drain
    int          m_own;
    int          edge_n;
    logic        e_wen, e_ren;
    logic [7:0]  e_waddr, e_raddr;
    logic [11:0] e_wdata, e_rdata;
    logic [3:0]  e_rvalid, e_err;

    task automatic model_reset();
        pend.delete();
        m_st = 0; m_own = 0;
        e_wen = 0; e_ren = 0; e_waddr = 0; e_raddr = 0; e_wdata = 0; e_rdata = 0;
        e_rvalid = 0; e_err = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        int  infl;
        int  s;
        bit  okv;
        bit  fwd;
        edge_n++;
        infl = pend.size();
        s    = int'(sel);
        okv  = sel_valid && (s < NCH);
        fwd  = (m_st == 1);
        e_rvalid = 4'b0000;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            e_rvalid = 4'b0001 << pend[0].tag;
            e_rdata  = rom(pend[0].addr);
            void'(pend.pop_front());
        end
        e_wen = fwd && ch_wen[m_own];
        if (e_wen) begin
            e_waddr = ch_waddr[m_own*8 +: 8];
            e_wdata = ch_wdata[m_own*12 +: 12];
        end
        e_ren = fwd && ch_ren[m_own];
        if (e_ren) begin
            e_raddr = ch_raddr[m_own*8 +: 8];
            pend.push_back('{edge_n + RD_LAT + 1, m_own, e_raddr});
        end
        for (int i = 0; i < NCH; i++) begin
            if ((ch_wen[i] || ch_ren[i]) && !(fwd && i == m_own)) e_err[i] = 1'b1;
            else if (err_clr) e_err[i] = 1'b0;
        end
        if (m_st == 0) begin
            if (okv) begin m_st = 1; m_own = s; end
        end else if (m_st == 1) begin
            if (!sel_valid || (okv && s != m_own)) begin
                if (infl == 0) begin
                    if (okv) m_own = s;
                    else m_st = 0;
                end else begin
                    m_st = 2;
                end
            end
        end else begin
            if (infl == 0) begin
                if (okv) begin m_st = 1; m_own = s; end
                else m_st = 0;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("gnt_valid", gnt_valid, m_st == 1);
        if (m_st == 1) check_eq("gnt", gnt, m_own);
        check_eq("busy", busy, (m_st != 0) || (pend.size() != 0));
        check_eq("mem_wen", mem_wen, e_wen);
        check_eq("mem_waddr", mem_waddr, e_waddr);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("mem_ren", mem_ren, e_ren);
        check_eq("mem_raddr", mem_raddr, e_raddr);
        check_eq("ch_rvalid", ch_rvalid, e_rvalid);
        check_eq("ch_rdata", ch_rdata, e_rdata);
        check_eq("err_vec", err_vec, e_err);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_acc();
        ch_wen = '0; ch_ren = '0; err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_zero_ctl"},
                 {mem_wen, mem_ren, gnt_valid, busy, ch_rvalid, err_vec, gnt}, 32'h0);
        check_eq({tag, "_zero_addr"}, {mem_waddr, mem_raddr}, 32'h0);
        check_eq({tag, "_zero_data"}, {mem_wdata, ch_rdata}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; sel_valid = 1'b0; sel = '0; sel_valid3 = 1'b0; sel3 = '0;
        ch_waddr = '0; ch_wdata = '0; ch_raddr = '0; edge_n = 0;
        clear_acc();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Grant ch2, ch2 writes 0x05 <- 0xABC.
        sel_valid = 1'b1; sel = 2'd2;
        cycle();
        check_eq("t1_gnt_valid", gnt_valid, 1);
        check_eq("t1_gnt", gnt, 2);
        ch_wen = 4'b0100; ch_waddr[2*8 +: 8] = 8'h05; ch_wdata[2*12 +: 12] = 12'hABC;
        cycle();
        check_eq("t1_wen", mem_wen, 1);
        check_eq("t1_waddr", mem_waddr, 8'h05);
        check_eq("t1_wdata", mem_wdata, 12'hABC);

        // Switch to ch1 with nothing in flight, then read 0x10.
        clear_acc(); sel = 2'd1;
        cycle();
        check_eq("t2_gnt", gnt, 1);
        ch_ren = 4'b0010; ch_raddr[1*8 +: 8] = 8'h10;
        cycle();
        clear_acc();
        cycle();
        cycle();
        check_eq("t2_rvalid", ch_rvalid, 4'b0010);
        check_eq("t2_rdata", ch_rdata, 12'h123);

        // Owner change with a read in flight drains first; ch3 strays meanwhile.
        ch_ren = 4'b0010; ch_raddr[1*8 +: 8] = 8'h20;
        cycle();
        clear_acc(); sel = 2'd3; ch_ren = 4'b1000; ch_raddr[3*8 +: 8] = 8'h33;
        cycle();
        check_eq("t3_drain_gv", gnt_valid, 0);
        check_eq("t3_drain_busy", busy, 1);
        check_eq("t3_err3", err_vec[3], 1);
        cycle();
        check_eq("t3_rvalid", ch_rvalid, 4'b0010);
        check_eq("t3_rdata", ch_rdata, rom(8'h20));
        check_eq("t3_dropped", mem_ren, 0);
        clear_acc();
        cycle();
        check_eq("t3_gv", gnt_valid, 1);
        check_eq("t3_gnt", gnt, 3);

        // Release with nothing pending; out-of-range sel on the 3-channel instance.
        sel_valid = 1'b0;
        sel_valid3 = 1'b1; sel3 = 2'd3;
        cycle();
        check_eq("t4_idle_gv", gnt_valid, 0);
        check_eq("t4_idle_busy", busy, 0);
        cycle();
        check_eq("t4_bad_sel_gv", gnt_valid3, 0);
        check_eq("t4_bad_sel_busy", busy3, 0);
        sel3 = 2'd2;
        cycle();
        check_eq("t4_sel2_gv", gnt_valid3, 1);
        check_eq("t4_sel2_gnt", gnt3, 2);
        sel_valid3 = 1'b0;

        // Stray access beats a simultaneous clear.
        ch_wen = 4'b0001; err_clr = 1'b1;
        cycle();
        check_eq("t5_err_set_wins", err_vec, 4'b0001);
        ch_wen = '0;
        cycle();
        check_eq("t5_err_cleared", err_vec, 4'b0000);
        clear_acc();

        // Reset with two reads in flight.
        sel_valid = 1'b1; sel = 2'd0;
        cycle();
        ch_ren = 4'b0001; ch_raddr[7:0] = 8'h44;
        cycle();
        ch_raddr[7:0] = 8'h45;
        cycle();
        clear_acc();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("midrst_no_rvalid", ch_rvalid, 4'b0000);
        end

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel_valid = ($urandom_range(0, 4) != 0);
                sel       = 2'($urandom_range(0, 3));
            end
            ch_wen   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            ch_ren   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            ch_waddr = $urandom;
            ch_raddr = $urandom;
            ch_wdata = {16'($urandom), 32'($urandom)};
            err_clr  = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
